// File: rtl/debug_probe_mux.sv
// debug_probe_mux
//   Selects one of NCH probe channels for display, either from the manual
//   select switches or from an automatic scan that dwells DWELL cycles per
//   channel. A freeze input holds the displayed value, channel and scan
//   position. All outputs are registered (one cycle of latency).
//
// Ports
//   clk      : clock, all logic on the rising edge
//   reset    : synchronous, active-high reset
//   sel      : manual channel select (ignored in auto-scan)
//   auto_en  : 1 = auto-scan, 0 = manual
//   freeze   : hold displayed value/channel, pause the scan
//   ch_data  : packed channels, channel k at [k*WIDTH +: WIDTH]
//   vdata    : displayed data (16'hDEAD, resized to WIDTH, for an invalid select)
//   sel_led  : one-hot displayed channel (all ones for an invalid select)
//   cur_ch   : displayed channel index
//   frozen   : 1 while the output is held
//   changed  : data-change pulse on an unchanged channel
//
// Build option
//   PROBE_CHANGE_DET_EN : when defined, enables the change-detect pulse on
//                         'changed'; otherwise 'changed' is constant 0.
module debug_probe_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int SEL_W = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   auto_en,
  input  logic                   freeze,
  input  logic [NCH*WIDTH-1:0]   ch_data,
  output logic [WIDTH-1:0]       vdata,
  output logic [NCH-1:0]         sel_led,
  output logic [SEL_W-1:0]       cur_ch,
  output logic                   frozen,
  output logic                   changed
);

  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]  IDX_LAST = SEL_W'(NCH - 1);
  // One extra bit so NCH == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]    NCH_V    = (SEL_W + 1)'(NCH);
  localparam logic [WIDTH-1:0]  BAD_DATA = WIDTH'(16'hDEAD);

  // Unpacked view of the channel bus.
  logic [WIDTH-1:0] ch_arr [NCH];
  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign ch_arr[gi] = ch_data[gi*WIDTH +: WIDTH];
  end

  logic [SEL_W-1:0] scan_q,   scan_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             auto_q,   auto_d;   // mode seen on the last unfrozen cycle
  logic [WIDTH-1:0] vdata_q,  vdata_d;
  logic [NCH-1:0]   led_q,    led_d;
  logic [SEL_W-1:0] cur_q,    cur_d;
  logic             frozen_q, frozen_d;
  logic             chg_q,    chg_d;

  logic [SEL_W-1:0] disp_idx;
  logic             in_range;
  logic [WIDTH-1:0] mux_data;
  logic [NCH-1:0]   mux_led;

  always_comb begin
    scan_d   = scan_q;
    cnt_d    = cnt_q;
    auto_d   = auto_q;
    vdata_d  = vdata_q;
    led_d    = led_q;
    cur_d    = cur_q;
    frozen_d = freeze;
    chg_d    = 1'b0;
    disp_idx = sel;
    in_range = 1'b0;
    mux_data = '0;
    mux_led  = '0;

    if (freeze) begin
      // A dwell that expires while frozen loses its advance; the dwell
      // restarts so the next step needs a full dwell after release.
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end
    end else begin
      auto_d = auto_en;
      if (auto_en) begin
        if (!auto_q) begin
          // Entering auto-scan: start at channel 0 with a fresh dwell.
          scan_d = '0;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          scan_d = (scan_q == IDX_LAST) ? '0 : scan_q + SEL_W'(1);
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
        disp_idx = scan_d;
        in_range = 1'b1;
      end else begin
        disp_idx = sel;
        in_range = ({1'b0, sel} < NCH_V);
      end

      for (int k = 0; k < NCH; k++) begin
        if (disp_idx == SEL_W'(k)) begin
          mux_data   = ch_arr[k];
          mux_led[k] = 1'b1;
        end
      end

      cur_d   = disp_idx;
      vdata_d = in_range ? mux_data : BAD_DATA;
      led_d   = in_range ? mux_led  : '1;
`ifdef PROBE_CHANGE_DET_EN
      chg_d   = (cur_d == cur_q) && (vdata_d != vdata_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_q   <= '0;
      cnt_q    <= '0;
      auto_q   <= 1'b0;
      vdata_q  <= '0;
      led_q    <= '0;
      cur_q    <= '0;
      frozen_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      scan_q   <= scan_d;
      cnt_q    <= cnt_d;
      auto_q   <= auto_d;
      vdata_q  <= vdata_d;
      led_q    <= led_d;
      cur_q    <= cur_d;
      frozen_q <= frozen_d;
      chg_q    <= chg_d;
    end
  end

  assign vdata   = vdata_q;
  assign sel_led = led_q;
  assign cur_ch  = cur_q;
  assign frozen  = frozen_q;
  assign changed = chg_q;

endmodule

// File: tb/tb_debug_probe_mux.sv
// Testbench for debug_probe_mux: directed cases with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_debug_probe_mux;

  localparam int WIDTH = 32;
  localparam int NCH   = 5;
  localparam int SEL_W = 3;
  localparam int DWELL = 3;

`ifdef PROBE_CHANGE_DET_EN
  localparam bit CDET = 1'b1;
`else
  localparam bit CDET = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [SEL_W-1:0]     sel;
  logic                 auto_en;
  logic                 freeze;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [WIDTH-1:0]     vdata;
  logic [NCH-1:0]       sel_led;
  logic [SEL_W-1:0]     cur_ch;
  logic                 frozen;
  logic                 changed;

  logic [31:0] chv [NCH];

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NCH; k++) ch_data[k*WIDTH +: WIDTH] = chv[k];
  end

  debug_probe_mux #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .sel(sel), .auto_en(auto_en), .freeze(freeze),
    .ch_data(ch_data), .vdata(vdata), .sel_led(sel_led), .cur_ch(cur_ch),
    .frozen(frozen), .changed(changed)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scan position is tracked as (channel, cycles left before the next step).
  bit          model_valid = 1'b0;
  int          m_idx, m_left, m_ch;
  bit          m_prev_auto;
  logic [31:0] m_nv;
  logic [31:0] e_vdata;
  logic [NCH-1:0] e_led;
  int          e_cur;
  bit          e_frozen, e_changed;

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1'b1;
      m_idx = 0; m_left = DWELL - 1; m_prev_auto = 1'b0;
      e_vdata = 0; e_led = '0; e_cur = 0; e_frozen = 1'b0; e_changed = 1'b0;
    end else if (model_valid) begin
      if (freeze) begin
        e_frozen = 1'b1;
        e_changed = 1'b0;
        if (m_left == 0) m_left = DWELL - 1;   // expiry swallowed by freeze
      end else begin
        if (auto_en) begin
          if (!m_prev_auto) begin
            m_idx = 0; m_left = DWELL - 1;
          end else if (m_left == 0) begin
            m_idx = (m_idx + 1) % NCH; m_left = DWELL - 1;
          end else begin
            m_left = m_left - 1;
          end
          m_ch = m_idx;
        end else begin
          m_ch = int'(sel);
        end
        m_prev_auto = auto_en;
        if (m_ch < NCH) begin
          m_nv = chv[m_ch];
          e_led = '0;
          e_led[m_ch] = 1'b1;
        end else begin
          m_nv = 32'h0000DEAD;
          e_led = '1;
        end
        e_changed = CDET && (m_ch == e_cur) && (m_nv != e_vdata);
        e_cur = m_ch;
        e_vdata = m_nv;
        e_frozen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_vdata",   vdata,              e_vdata);
      chk("model_sel_led", 32'(sel_led),       32'(e_led));
      chk("model_cur_ch",  32'(cur_ch),        32'(e_cur));
      chk("model_frozen",  32'(frozen),        32'(e_frozen));
      chk("model_changed", 32'(changed),       32'(e_changed));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sel = '0; auto_en = 1'b0; freeze = 1'b0;
    for (int k = 0; k < NCH; k++) chv[k] = 32'h1000 + k;
    tick();
    chk("reset_vdata",  vdata,          32'h0);
    chk("reset_led",    32'(sel_led),   32'h0);
    chk("reset_cur",    32'(cur_ch),    32'h0);
    chk("reset_frozen", 32'(frozen),    32'h0);
    tick();
    reset = 1'b0;

    // manual, in range
    sel = 3'd3; tick();
    chk("man_vdata", vdata,        32'h1003);
    chk("man_led",   32'(sel_led), 32'b01000);
    chk("man_cur",   32'(cur_ch),  32'd3);

    // manual, out of range
    sel = 3'd6; tick();
    chk("oor_vdata", vdata,        32'h0000DEAD);
    chk("oor_led",   32'(sel_led), 32'b11111);
    chk("oor_cur",   32'(cur_ch),  32'd6);

    // change detect
    sel = 3'd2; chv[2] = 32'd5; tick();
    chk("cd_switch", 32'(changed), 32'd0);
    tick();
    chk("cd_steady", 32'(changed), 32'd0);
    chv[2] = 32'd6; tick();
    chk("cd_pulse",  32'(changed), 32'(CDET));
    chk("cd_vdata",  vdata,        32'd6);
    tick();
    chk("cd_once",   32'(changed), 32'd0);
    sel = 3'd1; tick();
    chk("cd_selchg", 32'(changed), 32'd0);

    // auto-scan from entry: channel i/DWELL, wrapping
    sel = 3'd7; auto_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("scan_cur",   32'(cur_ch), 32'((i / DWELL) % NCH));
      chk("scan_vdata", vdata,       32'h1000 + 32'((i / DWELL) % NCH) + ((i / DWELL) % NCH == 2 ? 32'd6 - 32'h1002 : 32'd0));
    end

    // freeze on the cycle the dwell would expire
    tick(); tick();
    chk("pre_frz_cur", 32'(cur_ch), 32'd0);
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("frz_cur",    32'(cur_ch), 32'd0);
      chk("frz_flag",   32'(frozen), 32'd1);
      chk("frz_vdata",  vdata,       32'h1000);
    end
    freeze = 1'b0;
    tick(); chk("rel_cur0", 32'(cur_ch), 32'd0); chk("rel_flag", 32'(frozen), 32'd0);
    tick(); chk("rel_cur1", 32'(cur_ch), 32'd0);
    tick(); chk("rel_cur2", 32'(cur_ch), 32'd1);

    // reset while frozen, mid-dwell, in auto mode
    tick();
    freeze = 1'b1; tick();
    reset = 1'b1; tick();
    chk("rst_vdata",  vdata,          32'h0);
    chk("rst_led",    32'(sel_led),   32'h0);
    chk("rst_cur",    32'(cur_ch),    32'h0);
    chk("rst_frozen", 32'(frozen),    32'h0);
    chk("rst_chg",    32'(changed),   32'h0);
    reset = 1'b0; freeze = 1'b0;
    tick(); chk("rst_scan0", 32'(cur_ch), 32'd0);
    tick(); tick(); chk("rst_scan1", 32'(cur_ch), 32'd0);
    tick(); chk("rst_scan2", 32'(cur_ch), 32'd1);

    // back to manual on the next cycle
    auto_en = 1'b0; sel = 3'd4; tick();
    chk("man_back", 32'(cur_ch), 32'd4);

    // randomized phase, checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      freeze = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 7) == 0) sel = SEL_W'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) chv[$urandom_range(0, NCH - 1)] = $urandom_range(0, 3);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
